// File: rtl/cart_bus_ctrl.sv
// Cartridge bus initiator: turns single-beat core requests into paced
// setup / strobe / hold bus cycles on the cartridge connector.
module cart_bus_ctrl #(
  parameter int unsigned SETUP_CYCLES  = 1,
  parameter int unsigned STROBE_CYCLES = 2,
  parameter int unsigned HOLD_CYCLES   = 1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_write,
  input  logic [15:0] i_req_adr,
  input  logic [7:0]  i_req_data,
  output logic        o_rsp_valid,
  output logic [7:0]  o_rsp_data,
  output logic [15:0] o_cart_adr,
  output logic [7:0]  o_cart_dout,
  output logic        o_cart_doe,
  input  logic [7:0]  i_cart_din,
  output logic        o_cart_nrd,
  output logic        o_cart_nwr,
  output logic        o_cart_ncs
);

  typedef enum logic [1:0] {StIdle, StSetup, StStrobe, StHold} state_e;

  localparam logic [3:0] SetupLoad  = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] StrobeLoad = 4'(STROBE_CYCLES - 1);
  localparam logic [3:0] HoldLoad   = 4'(HOLD_CYCLES - 1);

  state_e      r_state;
  state_e      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic        r_ready;
  logic        r_write;
  logic        w_accept;
  logic        w_ram_area;
  logic        r_rsp_valid;
  logic [7:0]  r_rsp_data;
  logic [15:0] r_adr;
  logic [7:0]  r_dout;
  logic        r_doe;
  logic        r_nrd;
  logic        r_nwr;
  logic        r_ncs;

  // r_ready mirrors "state is IDLE"; reset masks it without waiting for an edge.
  assign o_req_ready = r_ready && !i_reset;
  assign w_accept    = i_req_valid && o_req_ready;
  assign w_ram_area  = (i_req_adr >= 16'hA000) && (i_req_adr <= 16'hFDFF);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_state_nxt = StSetup;
          w_cnt_nxt   = SetupLoad;
        end
      end
      StSetup: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = StStrobe;
          w_cnt_nxt   = StrobeLoad;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      StStrobe: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = StHold;
          w_cnt_nxt   = HoldLoad;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      StHold: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = StIdle;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= StIdle;
      r_cnt       <= 4'd0;
      r_ready     <= 1'b1;
      r_write     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 8'h00;
      r_adr       <= 16'h0000;
      r_dout      <= 8'h00;
      r_doe       <= 1'b0;
      r_nrd       <= 1'b1;
      r_nwr       <= 1'b1;
      r_ncs       <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_ready     <= (w_state_nxt == StIdle);
      r_rsp_valid <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_write <= i_req_write;
            r_adr   <= i_req_adr;
            r_doe   <= i_req_write;
            r_ncs   <= !w_ram_area;
            if (i_req_write) r_dout <= i_req_data;
          end
        end
        StSetup: begin
          if (w_state_nxt == StStrobe) begin
            r_nrd <= r_write;
            r_nwr <= !r_write;
          end
        end
        StStrobe: begin
          if (w_state_nxt == StHold) begin
            r_nrd <= 1'b1;
            r_nwr <= 1'b1;
            if (!r_write) begin
              r_rsp_data  <= i_cart_din;
              r_rsp_valid <= 1'b1;
            end
          end
        end
        StHold: begin
          // Data and /CS stay put until here so the /WR rising edge sees them stable.
          if (w_state_nxt == StIdle) begin
            r_ncs <= 1'b1;
            r_doe <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_data  = r_rsp_data;
  assign o_cart_adr  = r_adr;
  assign o_cart_dout = r_dout;
  assign o_cart_doe  = r_doe;
  assign o_cart_nrd  = r_nrd;
  assign o_cart_nwr  = r_nwr;
  assign o_cart_ncs  = r_ncs;

endmodule
